// File: rtl/bmc_soft_pipe_if.sv
// Handshake bundle between the depuncturer, the branch-metric unit and the
// add-compare-select array. One trellis step per transfer on each side.
interface bmc_soft_pipe_if #(
    parameter int N_OUT  = 2,
    parameter int SOFT_W = 3,
    parameter int CNT_W  = 8
);
    localparam int BM_W = SOFT_W + $clog2(N_OUT);
    localparam int N_CW = 2 ** N_OUT;

    logic                   mode_soft;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*SOFT_W-1:0] in_sym;
    logic [N_OUT-1:0]       in_erase;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_CW*BM_W-1:0]   out_bm;
    logic                   out_last;
    logic [CNT_W-1:0]       out_step;

    // Source of steps / sink of metrics (depuncturer + ACS side)
    modport master (
        output mode_soft, in_valid, in_sym, in_erase, in_last, out_ready,
        input  in_ready, out_valid, out_bm, out_last, out_step
    );

    // The branch-metric unit itself
    modport slave (
        input  mode_soft, in_valid, in_sym, in_erase, in_last, out_ready,
        output in_ready, out_valid, out_bm, out_last, out_step
    );
endinterface

// File: rtl/bmc_soft_pipe.sv
// Parametrised soft/hard branch-metric unit for the Viterbi decoder.
// Stage 1 turns each received symbol into its distance to a '0' and to a '1'
// hypothesis (zero for punctured symbols); stage 2 sums those distances for
// every one of the 2**N_OUT codeword hypotheses. Two-deep valid/ready pipe,
// one step per cycle sustained, outputs frozen while the sink stalls.
module bmc_soft_pipe #(
    parameter int N_OUT  = 2,
    parameter int SOFT_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    bmc_soft_pipe_if.slave  bus
);
    localparam int BM_W = SOFT_W + $clog2(N_OUT);
    localparam int N_CW = 2 ** N_OUT;
    localparam logic [SOFT_W-1:0] SYM_MAX = {SOFT_W{1'b1}};

    logic                 s1_vld;
    logic                 s2_vld;
    logic                 s1_load;
    logic                 s2_load;
    logic [SOFT_W-1:0]    d0_c [N_OUT];
    logic [SOFT_W-1:0]    d1_c [N_OUT];
    logic [SOFT_W-1:0]    s1_d0 [N_OUT];
    logic [SOFT_W-1:0]    s1_d1 [N_OUT];
    logic                 s1_last;
    logic [CNT_W-1:0]     s1_step;
    logic [CNT_W-1:0]     step_cnt;
    logic [BM_W-1:0]      sum_c [N_CW];
    logic [N_CW*BM_W-1:0] s2_bm;
    logic                 s2_last;
    logic [CNT_W-1:0]     s2_step;

    // A stage may load when it is empty or its contents move on this cycle;
    // out_ready ripples straight through to in_ready on purpose.
    assign s2_load      = !s2_vld || bus.out_ready;
    assign s1_load      = !s1_vld || s2_load;
    assign bus.in_ready = s1_load;

    assign bus.out_valid = s2_vld;
    assign bus.out_bm    = s2_bm;
    assign bus.out_last  = s2_last;
    assign bus.out_step  = s2_step;

    // Per-symbol distances; hard mode looks only at the sign (MSB) bit,
    // and a punctured symbol must not bias any hypothesis.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            d0_c[i] = '0;
            d1_c[i] = '0;
            if (!bus.in_erase[i]) begin
                if (bus.mode_soft) begin
                    d0_c[i] = bus.in_sym[i*SOFT_W +: SOFT_W];
                    d1_c[i] = SYM_MAX - bus.in_sym[i*SOFT_W +: SOFT_W];
                end else begin
                    d0_c[i] = SOFT_W'(bus.in_sym[i*SOFT_W + SOFT_W - 1]);
                    d1_c[i] = SOFT_W'(!bus.in_sym[i*SOFT_W + SOFT_W - 1]);
                end
            end
        end
    end

    // Branch metric of codeword c: bit i of c selects the '1' or '0' distance of symbol i.
    always_comb begin
        for (int c = 0; c < N_CW; c++) begin
            sum_c[c] = '0;
            for (int i = 0; i < N_OUT; i++) begin
                if (((c >> i) & 1) != 0) begin
                    sum_c[c] = sum_c[c] + BM_W'(s1_d1[i]);
                end else begin
                    sum_c[c] = sum_c[c] + BM_W'(s1_d0[i]);
                end
            end
        end
    end

    // Stage 1: capture distances, frame flag and step index; the mode is
    // already folded into the distances, so in-flight steps keep their mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_step  <= '0;
            step_cnt <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                s1_d0[i] <= '0;
                s1_d1[i] <= '0;
            end
        end else if (s1_load) begin
            s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < N_OUT; i++) begin
                    s1_d0[i] <= d0_c[i];
                    s1_d1[i] <= d1_c[i];
                end
                s1_last  <= bus.in_last;
                s1_step  <= step_cnt;
                step_cnt <= bus.in_last ? '0 : step_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2: register all hypothesis sums; held untouched while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_bm   <= '0;
            s2_last <= 1'b0;
            s2_step <= '0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                for (int c = 0; c < N_CW; c++) begin
                    s2_bm[c*BM_W +: BM_W] <= sum_c[c];
                end
                s2_last <= s1_last;
                s2_step <= s1_step;
            end
        end
    end
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed bench for bmc_soft_pipe at N_OUT=2, SOFT_W=3, CNT_W=4 (BM_W=4).
// Inputs change and outputs are sampled around the falling clock edge.
module tb_bmc_soft_pipe;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    typedef struct {
        logic       mode;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [1:0] er;
        logic       last;
    } stim_t;

    typedef struct {
        logic [15:0] bm;
        logic [3:0]  step;
        logic        last;
    } resp_t;

    stim_t sq[$];
    resp_t rq[$];

    bmc_soft_pipe_if #(.N_OUT(2), .SOFT_W(3), .CNT_W(4)) bus();

    bmc_soft_pipe #(.N_OUT(2), .SOFT_W(3), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] bm4(input int b0, input int b1, input int b2, input int b3);
        logic [3:0] a0, a1, a2, a3;
        a0 = 4'(b0);
        a1 = 4'(b1);
        a2 = 4'(b2);
        a3 = 4'(b3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mode, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] er, input logic last);
        bus.in_valid  = 1'b1;
        bus.mode_soft = mode;
        bus.in_sym    = {s1, s0};
        bus.in_erase  = er;
        bus.in_last   = last;
    endtask

    task automatic push(input logic mode, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [1:0] er, input logic last,
                        input logic [15:0] bm, input int step);
        stim_t s;
        resp_t r;
        s.mode = mode; s.s0 = s0; s.s1 = s1; s.er = er; s.last = last;
        r.bm = bm; r.step = 4'(step); r.last = last;
        sq.push_back(s);
        rq.push_back(r);
    endtask

    // Streams the queued steps with out_ready high and checks each output in order.
    task automatic run_queues(input int budget);
        int    cyc;
        resp_t r;
        stim_t s;
        cyc = 0;
        while ((sq.size() != 0 || rq.size() != 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = 1'b1;
            if (sq.size() != 0) begin
                s = sq[0];
                drive(s.mode, s.s0, s.s1, s.er, s.last);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid) begin
                if (rq.size() == 0) begin
                    chk("extra_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    r = rq.pop_front();
                    chk("stream_bm", 32'(bus.out_bm), 32'(r.bm));
                    chk("stream_step", 32'(bus.out_step), 32'(r.step));
                    chk("stream_last", 32'(bus.out_last), 32'(r.last));
                end
            end
            if (bus.in_valid && bus.in_ready) void'(sq.pop_front());
        end
        bus.in_valid = 1'b0;
        chk("queues_drained", 32'(sq.size() + rq.size()), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mode_soft = 1'b1;
        bus.in_sym    = '0;
        bus.in_erase  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_bm", 32'(bus.out_bm), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_step", 32'(bus.out_step), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 1. soft 0/7, two-cycle latency
        drive(1'b1, 3'd0, 3'd7, 2'b00, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("t1_lat1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("t1_lat2_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_bm", 32'(bus.out_bm), 32'(bm4(7, 14, 0, 7)));
        chk("t1_step", 32'(bus.out_step), 32'd0);

        // 2. hard 3/4, then mode toggling per step; 3. erasures
        push(1'b0, 3'd3, 3'd4, 2'b00, 1'b0, bm4(1, 2, 0, 1), 1);
        push(1'b1, 3'd3, 3'd4, 2'b00, 1'b0, bm4(7, 8, 6, 7), 2);
        push(1'b0, 3'd3, 3'd4, 2'b00, 1'b0, bm4(1, 2, 0, 1), 3);
        push(1'b1, 3'd3, 3'd4, 2'b00, 1'b0, bm4(7, 8, 6, 7), 4);
        push(1'b0, 3'd3, 3'd4, 2'b00, 1'b0, bm4(1, 2, 0, 1), 5);
        push(1'b1, 3'd5, 3'd7, 2'b10, 1'b0, bm4(5, 2, 5, 2), 6);
        push(1'b1, 3'd3, 3'd4, 2'b11, 1'b0, bm4(0, 0, 0, 0), 7);
        run_queues(40);

        // 4. backpressure: A, B held, C waits
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd1, 3'd2, 2'b00, 1'b0);
        #1;
        chk("t4_rdy_a", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 3'd6, 3'd1, 2'b00, 1'b0);
        #1;
        chk("t4_rdy_b", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 3'd5, 3'd3, 2'b01, 1'b1);
        #1;
        chk("t4_stall_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_stall_rdy", 32'(bus.in_ready), 32'd0);
        chk("t4_stall_bm", 32'(bus.out_bm), 32'(bm4(3, 8, 6, 11)));
        chk("t4_stall_step", 32'(bus.out_step), 32'd8);
        @(negedge clk);
        #1;
        chk("t4_hold_rdy", 32'(bus.in_ready), 32'd0);
        chk("t4_hold_bm", 32'(bus.out_bm), 32'(bm4(3, 8, 6, 11)));
        chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("t4_release_rdy", 32'(bus.in_ready), 32'd1);
        chk("t4_a_bm", 32'(bus.out_bm), 32'(bm4(3, 8, 6, 11)));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("t4_b_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_b_bm", 32'(bus.out_bm), 32'(bm4(1, 0, 2, 1)));
        chk("t4_b_step", 32'(bus.out_step), 32'd9);
        @(negedge clk);
        #1;
        chk("t4_c_bm", 32'(bus.out_bm), 32'(bm4(3, 3, 4, 4)));
        chk("t4_c_step", 32'(bus.out_step), 32'd10);
        chk("t4_c_last", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        #1;
        chk("t4_drained", 32'(bus.out_valid), 32'd0);

        // 5. counter wrap, then last at index 5, then restart at 0
        for (int k = 0; k < 23; k++) begin
            int st;
            st = (k <= 16) ? (k % 16) : ((k <= 21) ? (k - 16) : 0);
            if ((k % 2) == 0)
                push(1'b1, 3'd2, 3'd6, 2'b00, k == 21, bm4(8, 11, 3, 6), st);
            else
                push(1'b0, 3'd7, 3'd0, 2'b00, k == 21, bm4(1, 0, 2, 1), st);
        end
        run_queues(80);

        // 6. async reset with two steps in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 3'd7, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd3, 3'd4, 2'b00, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_pre_step", 32'(bus.out_step), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_async_bm", 32'(bus.out_bm), 32'd0);
        chk("t6_async_step", 32'(bus.out_step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 3'd0, 3'd7, 2'b00, 1'b0);
        #1;
        chk("t6_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("t6_no_stale", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("t6_new_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_new_step", 32'(bus.out_step), 32'd0);
        chk("t6_new_bm", 32'(bus.out_bm), 32'(bm4(7, 14, 0, 7)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
